// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store controller for a word-wide data memory.
// Sub-word stores use a read-modify-write pair; rejected requests finish with error and no access.
module mem_access_unit #(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          MEMORY_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  write,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic [31:0]           MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    input  logic [DATA_WIDTH-1:0] MemReadData
);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, STW = 3'd2, RMW_RD = 3'd3, RMW_WR = 3'd4, DONE = 3'd5;

    logic [2:0]            state, state_nx;
    logic [1:0]            size_q;
    logic                  uns_q, err_q;
    logic [31:0]           off, off_q;
    logic [DATA_WIDTH-1:0] wdata_q, merge_q, ld_val, mask, ins;
    logic                  bad, accept, active;
    logic [4:0]            sh;
    logic [7:0]            ld_b;
    logic [15:0]           ld_h;

    // addr below BASE_ADDR wraps to a huge offset and fails the depth check
    assign off    = addr - BASE_ADDR;
    assign bad    = size == 2'b11 || (size == 2'b01 && off[0]) || (size == 2'b10 && off[1:0] != 2'b00)
                    || off[31:2] >= 30'(MEMORY_DEPTH);
    assign accept = state == IDLE && req;

    assign state_nx = state == IDLE   ? (!req ? IDLE : bad ? DONE : !write ? LOAD : size == 2'b10 ? STW : RMW_RD) :
                      state == RMW_RD ? RMW_WR :
                      (state == LOAD || state == STW || state == RMW_WR) ? DONE : IDLE;

    assign sh     = {off_q[1:0], 3'b000};
    assign ld_b   = MemReadData[sh +: 8];
    assign ld_h   = off_q[1] ? MemReadData[31:16] : MemReadData[15:0];
    assign ld_val = size_q == 2'b00 ? {{24{~uns_q & ld_b[7]}}, ld_b} :
                    size_q == 2'b01 ? {{16{~uns_q & ld_h[15]}}, ld_h} : MemReadData;

    // replicate the store lane across the word, then let the shifted mask pick the target lane
    assign mask   = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign ins    = size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
    assign active = state == LOAD || state == STW || state == RMW_RD || state == RMW_WR;

    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign error        = done & err_q;
    assign MemRead      = state == LOAD || state == RMW_RD;
    assign MemWrite     = state == STW || state == RMW_WR;
    assign MemAddress   = active ? BASE_ADDR + {2'b00, off_q[31:2]} : BASE_ADDR;
    assign MemWriteData = state == STW ? wdata_q : state == RMW_WR ? (merge_q & ~mask) | (ins & mask) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                size_q  <= size;
                uns_q   <= unsigned_ld;
                off_q   <= off;
                wdata_q <= wdata;
                err_q   <= bad;
            end
            if (state == LOAD) rdata <= ld_val;
            if (state == RMW_RD) merge_q <= MemReadData;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scenarios against a behavioural word memory,
// each task comparing observed outputs with hand-computed values.
module tb_mem_access_unit;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk, reset, req, write, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, MemAddress, MemWriteData, MemReadData;
    logic        busy, done, error, MemWrite, MemRead;
    logic        poke;
    logic [9:0]  pidx;
    logic [31:0] pval;
    logic [31:0] mem [1024];
    int          errors = 0, checks = 0;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req(req), .write(write), .size(size), .unsigned_ld(unsigned_ld),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error), .rdata(rdata),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign MemReadData = mem[10'(MemAddress - BASE)];

    always @(posedge clk) begin
        if (poke) mem[pidx] <= pval;
        else if (MemWrite) mem[10'(MemAddress - BASE)] <= MemWriteData;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic put(input logic [9:0] i, input logic [31:0] v);
        poke = 1'b1; pidx = i; pval = v;
        @(posedge clk); #1;
        poke = 1'b0;
    endtask

    // issues one request from IDLE and observes up to 6 cycles until done; returns to IDLE
    task automatic run(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d,
                       output int dk, output int nrd, output int nwr, output int both,
                       output logic er, output logic [31:0] wd, output logic [31:0] ma);
        dk = 0; nrd = 0; nwr = 0; both = 0; er = 1'b0; wd = 32'h0; ma = BASE;
        req = 1'b1; write = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 1; k <= 6 && dk == 0; k++) begin
            if (MemRead) begin nrd++; ma = MemAddress; end
            if (MemWrite) begin nwr++; wd = MemWriteData; ma = MemAddress; end
            if (MemRead && MemWrite) both++;
            if (done) begin dk = k; er = error; end
            if (dk == 0) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b want 00", done, error); end
        checks++; if (MemWrite !== 1'b0 || MemRead !== 1'b0) begin errors++; $display("FAIL reset_memctl: got %b%b want 00", MemWrite, MemRead); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (MemWriteData !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", MemWriteData); end
        checks++; if (MemAddress !== BASE) begin errors++; $display("FAIL reset_addr: got %h want %h", MemAddress, BASE); end
    endtask

    task automatic test_word;
        int dk, nrd, nwr, both; logic er; logic [31:0] wd, ma;
        run(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, dk, nrd, nwr, both, er, wd, ma);
        checks++; if (dk !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", dk); end
        checks++; if (nwr !== 1 || nrd !== 0) begin errors++; $display("FAIL sw_access: got wr=%0d rd=%0d want 1/0", nwr, nrd); end
        checks++; if (ma !== BASE + 32'd2) begin errors++; $display("FAIL sw_addr: got %h want %h", ma, BASE + 32'd2); end
        checks++; if (wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_data: got %h want deadbeef", wd); end
        checks++; if (mem[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_mem: got %h want deadbeef", mem[2]); end
        checks++; if (rdata !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_rdata_err: got %h/%b want 0/0", rdata, er); end
        run(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, dk, nrd, nwr, both, er, wd, ma);
        checks++; if (dk !== 2 || nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL lw_timing: got dk=%0d rd=%0d wr=%0d want 2/1/0", dk, nrd, nwr); end
        checks++; if (rdata !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data: got %h/%b want deadbeef/0", rdata, er); end
    endtask

    task automatic test_rmw;
        int dk, nrd, nwr, both; logic er; logic [31:0] wd, ma;
        put(10'd2, 32'h1122_3344);
        run(1'b1, 2'b00, 1'b0, 32'h1001_000A, 32'h1234_56AB, dk, nrd, nwr, both, er, wd, ma);
        checks++; if (dk !== 3 || nrd !== 1 || nwr !== 1 || both !== 0) begin errors++; $display("FAIL sb_timing: got dk=%0d rd=%0d wr=%0d both=%0d want 3/1/1/0", dk, nrd, nwr, both); end
        checks++; if (wd !== 32'h11AB_3344) begin errors++; $display("FAIL sb_merge: got %h want 11ab3344", wd); end
        checks++; if (mem[2] !== 32'h11AB_3344) begin errors++; $display("FAIL sb_mem: got %h want 11ab3344", mem[2]); end
        put(10'd3, 32'hAABB_CCDD);
        run(1'b1, 2'b01, 1'b0, 32'h1001_000E, 32'h9999_1234, dk, nrd, nwr, both, er, wd, ma);
        checks++; if (wd !== 32'h1234_CCDD || mem[3] !== 32'h1234_CCDD) begin errors++; $display("FAIL sh_merge: got %h mem %h want 1234ccdd", wd, mem[3]); end
        run(1'b1, 2'b00, 1'b0, 32'h1001_000F, 32'h0000_0077, dk, nrd, nwr, both, er, wd, ma);
        checks++; if (mem[3] !== 32'h7734_CCDD) begin errors++; $display("FAIL sb_lane3: got %h want 7734ccdd", mem[3]); end
    endtask

    task automatic test_subword_loads;
        int dk, nrd, nwr, both; logic er; logic [31:0] wd, ma;
        logic [31:0] la [6];
        logic [1:0]  ls [6];
        logic        lu [6];
        logic [31:0] lx [6];
        la = '{32'h1001_0015, 32'h1001_0016, 32'h1001_0016, 32'h1001_0016, 32'h1001_0017, 32'h1001_0014};
        ls = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        lu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        lx = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_0080, 32'h0000_7F01};
        put(10'd5, 32'h80FF_7F01);
        for (int i = 0; i < 6; i++) begin
            run(1'b0, ls[i], lu[i], la[i], 32'h0, dk, nrd, nwr, both, er, wd, ma);
            checks++; if (rdata !== lx[i] || dk !== 2 || er !== 1'b0) begin errors++; $display("FAIL ld_%0d: got %h dk=%0d err=%b want %h dk=2 err=0", i, rdata, dk, er, lx[i]); end
        end
    endtask

    task automatic test_errors;
        int dk, nrd, nwr, both; logic er; logic [31:0] wd, ma;
        logic [31:0] ea [5];
        logic [1:0]  es [5];
        logic        ew [5];
        ea = '{32'h1001_0001, 32'h1001_0002, 32'h1001_0000, 32'h1000_FFFC, BASE + 32'd4096};
        es = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
        ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        put(10'd4, 32'h0BAD_CAFE);
        run(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, dk, nrd, nwr, both, er, wd, ma);
        for (int i = 0; i < 5; i++) begin
            run(ew[i], es[i], 1'b0, ea[i], 32'h5555_5555, dk, nrd, nwr, both, er, wd, ma);
            checks++; if (dk !== 1 || er !== 1'b1) begin errors++; $display("FAIL err_%0d_flag: got dk=%0d err=%b want 1/1", i, dk, er); end
            checks++; if (nrd !== 0 || nwr !== 0 || rdata !== 32'h0BAD_CAFE) begin errors++; $display("FAIL err_%0d_side: got rd=%0d wr=%0d rdata=%h want 0/0/0badcafe", i, nrd, nwr, rdata); end
        end
        put(10'd1023, 32'hCAFE_F00D);
        run(1'b0, 2'b10, 1'b0, BASE + 32'd4092, 32'h0, dk, nrd, nwr, both, er, wd, ma);
        checks++; if (dk !== 2 || er !== 1'b0 || rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL last_word: got dk=%0d err=%b rdata=%h want 2/0/cafef00d", dk, er, rdata); end
    endtask

    task automatic test_busy;
        int dn, dk;
        logic [5:0] bb;
        dn = 0; dk = 0; bb = '0;
        put(10'd7, 32'hFFFF_FFFF);
        req = 1'b1; write = 1'b1; size = 2'b00; unsigned_ld = 1'b0; addr = 32'h1001_001D; wdata = 32'h55;
        @(posedge clk); #1;
        for (int k = 1; k <= 6; k++) begin
            bb[k-1] = busy;
            if (done) begin dn++; dk = k; end
            req = k <= 2; write = 1'b0; size = 2'b10; addr = 32'h1001_0000;
            @(posedge clk); #1;
        end
        checks++; if (dn !== 1 || dk !== 3) begin errors++; $display("FAIL busy_done: got count=%0d at=%0d want 1 at 3", dn, dk); end
        checks++; if (bb !== 6'b000111) begin errors++; $display("FAIL busy_flag: got %b want 000111", bb); end
        checks++; if (mem[7] !== 32'hFFFF_55FF) begin errors++; $display("FAIL busy_mem: got %h want ffff55ff", mem[7]); end
    endtask

    task automatic test_back_to_back;
        logic [5:0]  dd;
        logic        b3;
        logic [31:0] r3;
        dd = '0; b3 = 1'b1; r3 = '0;
        put(10'd10, 32'h0102_0304);
        put(10'd11, 32'h0506_0708);
        req = 1'b1; write = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h1001_0028;
        @(posedge clk); #1;
        for (int k = 1; k <= 6; k++) begin
            dd[k-1] = done;
            if (k == 3) begin b3 = busy; r3 = rdata; end
            if (k == 2) addr = 32'h1001_002C;
            if (k == 5) req = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (dd !== 6'b010010) begin errors++; $display("FAIL b2b_done: got %b want 010010", dd); end
        checks++; if (b3 !== 1'b0 || r3 !== 32'h0102_0304) begin errors++; $display("FAIL b2b_idle: got busy=%b rdata=%h want 0/01020304", b3, r3); end
        checks++; if (rdata !== 32'h0506_0708) begin errors++; $display("FAIL b2b_rdata: got %h want 05060708", rdata); end
    endtask

    task automatic test_reset_mid;
        int dn;
        dn = 0;
        put(10'd9, 32'h9988_7766);
        req = 1'b1; write = 1'b1; size = 2'b00; addr = 32'h1001_0024; wdata = 32'h11;
        @(posedge clk); #1;
        req = 1'b0;
        checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL rst_pre: got MemRead=%b want 1", MemRead); end
        reset = 1'b0; #1;
        checks++; if (busy !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_ctl: got busy=%b rd=%b wr=%b done=%b want 0000", busy, MemRead, MemWrite, done); end
        checks++; if (MemAddress !== BASE || MemWriteData !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_data: got addr=%h wd=%h rdata=%h want %h/0/0", MemAddress, MemWriteData, rdata, BASE); end
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++; if (dn !== 0 || mem[9] !== 32'h9988_7766) begin errors++; $display("FAIL rst_rmw: got dones=%0d mem=%h want 0/99887766", dn, mem[9]); end
        req = 1'b1; write = 1'b1; size = 2'b10; addr = 32'h1001_0024; wdata = 32'hDEAD_0000;
        @(posedge clk); #1;
        req = 1'b0;
        checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL rst_stw_pre: got MemWrite=%b want 1", MemWrite); end
        reset = 1'b0; #1;
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_stw_fall: got MemWrite=%b want 0", MemWrite); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem[9] !== 32'h9988_7766 || done !== 1'b0) begin errors++; $display("FAIL rst_stw_mem: got mem=%h done=%b want 99887766/0", mem[9], done); end
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; write = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        addr = 32'h0; wdata = 32'h0; poke = 1'b0; pidx = '0; pval = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        test_word;
        test_rmw;
        test_subword_loads;
        test_errors;
        test_busy;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
